// File: rtl/led_frame_ram_pkg.sv
// Shared constants for the light-pen frame buffer: top-level mode codes,
// the default clock rate and the controller state encoding.
package led_frame_ram_pkg;

  localparam int CLOCK_FREQ = 50_000_000;

  localparam logic [3:0] MODE_IDLE = 4'd0;
  localparam logic [3:0] MODE_KEY  = 4'd1;
  localparam logic [3:0] MODE_PEN  = 4'd2;
  localparam logic [3:0] MODE_DRAW = 4'd3;

  typedef enum logic [1:0] {
    FSM_CLEAR,
    FSM_IDLE,
    FSM_COLLECT,
    FSM_COMMIT
  } fsm_t;

endpackage

// File: rtl/led_frame_ram_onehot_dec.sv
// One-hot to binary decoder. valid is high only when exactly one bit is set;
// idx is meaningless when valid is low.
module onehot_dec #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] code,
  output logic [W-1:0] idx,
  output logic         valid
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) idx = idx | W'(i);
    end
  end

  assign valid = (code != '0) && ((code & (code - N'(1))) == '0);

endmodule

// File: rtl/led_frame_ram.sv
// Light-pen frame buffer: one-hot pen writes (immediate or row-batched in DRAW
// mode), hardware clear sweep, and an independent registered scan read port.
module led_frame_ram
  import led_frame_ram_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DW       = 4,
  parameter int HOLD_CYC = CLOCK_FREQ,
  parameter int RA       = $clog2(ROWS),
  parameter int CA       = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      state,
  input  logic            pen_we,
  input  logic [ROWS-1:0] pen_row,
  input  logic [COLS-1:0] pen_col,
  input  logic [DW-1:0]   pen_data,
  input  logic            clr_req,
  input  logic [RA-1:0]   scan_row,
  input  logic [CA-1:0]   scan_col,
  output logic [DW-1:0]   scan_data,
  output logic            busy,
  output logic [RA-1:0]   last_row,
  output logic [CA-1:0]   last_col,
  output logic            wr_pulse
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int TW    = $clog2(HOLD_CYC + 1);

  logic [DW-1:0]   mem [CELLS];

  logic            we_d;
  logic [ROWS-1:0] lat_row;
  logic [COLS-1:0] lat_col;
  logic [DW-1:0]   lat_data;
  logic [3:0]      mode_d;

  fsm_t            fsm;
  logic [AW-1:0]   clr_addr;
  logic [RA-1:0]   row_buf;
  logic [DW-1:0]   data_buf;
  logic [COLS-1:0] col_mask;
  logic [TW-1:0]   timer;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  logic            rise, fall, hit, clear_trig, draw, accept;
  logic [ROWS-1:0] dec_row;
  logic [COLS-1:0] dec_col;
  logic [RA-1:0]   row_idx;
  logic [CA-1:0]   col_idx;
  logic            row_ok, col_ok;
  logic [CA-1:0]   commit_col;
  logic            commit_any;

  function automatic logic [AW-1:0] addr_of(input logic [RA-1:0] r, input logic [CA-1:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  assign rise = pen_we & ~we_d;
  assign fall = ~pen_we & we_d;

  // A rising edge decodes the live bus; a falling edge decodes what the rise latched.
  assign dec_row = rise ? pen_row : lat_row;
  assign dec_col = rise ? pen_col : lat_col;

  onehot_dec #(.N(ROWS)) u_row_dec (.code(dec_row), .idx(row_idx), .valid(row_ok));
  onehot_dec #(.N(COLS)) u_col_dec (.code(dec_col), .idx(col_idx), .valid(col_ok));

  assign hit        = row_ok & col_ok;
  assign draw       = (state == MODE_DRAW);
  assign clear_trig = clr_req | (state != mode_d);
  assign accept     = rise & hit & (row_idx == row_buf);

  // Lowest flagged column is committed first.
  always_comb begin
    commit_col = '0;
    commit_any = |col_mask;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (col_mask[i]) commit_col = CA'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_d     <= 1'b0;
      lat_row  <= '0;
      lat_col  <= '0;
      lat_data <= '0;
      mode_d   <= '0;
    end else begin
      we_d   <= pen_we;
      mode_d <= state;
      if (rise) begin
        lat_row  <= pen_row;
        lat_col  <= pen_col;
        lat_data <= pen_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= FSM_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      row_buf  <= '0;
      data_buf <= '0;
      col_mask <= '0;
      timer    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_pulse <= 1'b0;
      last_row <= '0;
      last_col <= '0;
    end else begin
      wr_en    <= 1'b0;
      wr_pulse <= 1'b0;
      if (clear_trig) begin
        fsm      <= FSM_CLEAR;
        clr_addr <= '0;
        busy     <= 1'b1;
        col_mask <= '0;
        timer    <= '0;
      end else begin
        case (fsm)
          FSM_CLEAR: begin
            wr_en   <= 1'b1;
            wr_addr <= clr_addr;
            wr_data <= '0;
            if (clr_addr == AW'(CELLS - 1)) begin
              fsm  <= FSM_IDLE;
              busy <= 1'b0;
            end else begin
              clr_addr <= clr_addr + AW'(1);
            end
          end
          FSM_IDLE: begin
            if (!draw) begin
              if (fall && hit) begin
                wr_en    <= 1'b1;
                wr_addr  <= addr_of(row_idx, col_idx);
                wr_data  <= lat_data;
                wr_pulse <= 1'b1;
                last_row <= row_idx;
                last_col <= col_idx;
              end
            end else if (rise && hit) begin
              row_buf  <= row_idx;
              data_buf <= pen_data;
              col_mask <= COLS'(1) << col_idx;
              timer    <= '0;
              fsm      <= FSM_COLLECT;
            end
          end
          FSM_COLLECT: begin
            if (accept) begin
              col_mask[col_idx] <= 1'b1;
              timer             <= '0;
            end else if (timer == TW'(HOLD_CYC - 1)) begin
              fsm  <= FSM_COMMIT;
              busy <= 1'b1;
            end else if (timer != '1) begin
              timer <= timer + TW'(1);
            end
          end
          FSM_COMMIT: begin
            if (commit_any) begin
              wr_en                <= 1'b1;
              wr_addr              <= addr_of(row_buf, commit_col);
              wr_data              <= data_buf;
              wr_pulse             <= 1'b1;
              last_row             <= row_buf;
              last_col             <= commit_col;
              col_mask[commit_col] <= 1'b0;
            end else begin
              fsm  <= FSM_IDLE;
              busy <= 1'b0;
            end
          end
          default: begin
            fsm      <= FSM_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        endcase
      end
    end
  end

  // NOTE: the pixel array has no reset so it can map onto RAM primitives;
  // the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_data <= '0;
    else        scan_data <= mem[addr_of(scan_row, scan_col)];
  end

endmodule

// File: tb/tb_led_frame_ram.sv
// Directed bench for led_frame_ram: an 8x8x4 instance with a short hold time
// and a 16x4x8 instance for the parameter corner, with a write scoreboard.
module tb_led_frame_ram;
  import led_frame_ram_pkg::*;

  typedef struct {
    int r;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] state;
  logic       clr_req;

  logic       pen_we;
  logic [7:0] pen_row, pen_col;
  logic [3:0] pen_data;
  logic [2:0] scan_row, scan_col;
  logic [3:0] scan_data;
  logic       busy, wr_pulse;
  logic [2:0] last_row, last_col;

  logic        pen_we2;
  logic [15:0] pen_row2;
  logic [3:0]  pen_col2;
  logic [7:0]  pen_data2;
  logic [3:0]  scan_row2;
  logic [1:0]  scan_col2;
  logic [7:0]  scan_data2;
  logic        busy2, wr_pulse2;
  logic [3:0]  last_row2;
  logic [1:0]  last_col2;

  int total = 0;
  int bad = 0;
  int pulses2 = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  led_frame_ram #(.ROWS(8), .COLS(8), .DW(4), .HOLD_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .pen_we(pen_we),
    .pen_row(pen_row), .pen_col(pen_col), .pen_data(pen_data), .clr_req(clr_req),
    .scan_row(scan_row), .scan_col(scan_col), .scan_data(scan_data), .busy(busy),
    .last_row(last_row), .last_col(last_col), .wr_pulse(wr_pulse)
  );

  led_frame_ram #(.ROWS(16), .COLS(4), .DW(8), .HOLD_CYC(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .state(state), .pen_we(pen_we2),
    .pen_row(pen_row2), .pen_col(pen_col2), .pen_data(pen_data2), .clr_req(clr_req),
    .scan_row(scan_row2), .scan_col(scan_col2), .scan_data(scan_data2), .busy(busy2),
    .last_row(last_row2), .last_col(last_col2), .wr_pulse(wr_pulse2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_pulse) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_last_row", 32'(last_row), 32'(mon_e.r));
        check("wr_last_col", 32'(last_col), 32'(mon_e.c));
      end
    end
    if (wr_pulse2) pulses2++;
  end

  task automatic expect_cell(input string tag, input int r, input int c, input int v);
    @(negedge clk);
    scan_row = 3'(r);
    scan_col = 3'(c);
    @(posedge clk);
    #1 check(tag, 32'(scan_data), 32'(v));
  endtask

  task automatic expect_all_zero(input string tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        expect_cell(tag, r, c, 0);
  endtask

  task automatic strobe(input logic [7:0] r, input logic [7:0] c, input logic [3:0] d);
    @(negedge clk);
    pen_row = r; pen_col = c; pen_data = d; pen_we = 1'b1;
    @(negedge clk);
    pen_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt, t1, t2;
    state = MODE_IDLE; clr_req = 1'b0;
    pen_we = 1'b0; pen_row = '0; pen_col = '0; pen_data = '0;
    scan_row = '0; scan_col = '0;
    pen_we2 = 1'b0; pen_row2 = '0; pen_col2 = '0; pen_data2 = '0;
    scan_row2 = '0; scan_col2 = '0;

    // Reset values, then length of the power-on sweep on both instances.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_scan_data", 32'(scan_data), 32'd0);
    check("rst_last_row", 32'(last_row), 32'd0);
    check("rst_last_col", 32'(last_col), 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    rst_n = 1'b1;
    cnt = 0; t1 = -1; t2 = -1;
    while ((busy || busy2) && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (!busy && t1 < 0) t1 = cnt;
      if (!busy2 && t2 < 0) t2 = cnt;
    end
    check("rst_sweep_len_8x8", 32'(t1), 32'd64);
    check("rst_sweep_len_16x4", 32'(t2), 32'd64);
    repeat (2) @(negedge clk);
    expect_all_zero("rst_cell_zero");

    // Non-DRAW immediate write.
    exp_q.push_back('{2, 4});
    strobe(8'h04, 8'h10, 4'hA);
    repeat (2) @(negedge clk);
    check("nd_pulse_seen", 32'(exp_q.size()), 32'd0);
    expect_cell("nd_cell_2_4", 2, 4, 4'hA);

    // Invalid one-hot codes are dropped.
    strobe(8'h04, 8'h00, 4'h5);
    strobe(8'h04, 8'h18, 4'h5);
    strobe(8'h0C, 8'h01, 4'h5);
    repeat (2) @(negedge clk);
    check("inv_busy", 32'(busy), 32'd0);
    check("inv_last_row", 32'(last_row), 32'd2);
    check("inv_last_col", 32'(last_col), 32'd4);
    expect_cell("inv_cell_2_4", 2, 4, 4'hA);
    expect_cell("inv_cell_2_0", 2, 0, 0);
    expect_cell("inv_cell_2_3", 2, 3, 0);
    expect_cell("inv_cell_2_7", 2, 7, 0);
    expect_cell("inv_cell_0_0", 0, 0, 0);

    // Entering DRAW clears; a row batch commits with the first write's data.
    @(negedge clk);
    state = MODE_DRAW;
    wait_idle("draw_clear_done");
    exp_q.push_back('{3, 1});
    exp_q.push_back('{3, 5});
    exp_q.push_back('{3, 7});
    strobe(8'h08, 8'h02, 4'h5);
    strobe(8'h08, 8'h20, 4'h6);
    strobe(8'h08, 8'h80, 4'h7);
    strobe(8'h40, 8'h01, 4'h9);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("draw_commits_done", 32'(exp_q.size()), 32'd0);
    wait_idle("draw_commit_done");
    expect_cell("draw_cell_3_1", 3, 1, 5);
    expect_cell("draw_cell_3_5", 3, 5, 5);
    expect_cell("draw_cell_3_7", 3, 7, 5);
    expect_cell("draw_cell_6_0", 6, 0, 0);
    expect_cell("draw_cell_3_0", 3, 0, 0);
    expect_cell("draw_cell_2_4_cleared", 2, 4, 0);

    // Mode change right after the first commit aborts the rest and clears.
    exp_q.push_back('{1, 2});
    exp_q.push_back('{1, 4});
    exp_q.push_back('{1, 6});
    strobe(8'h02, 8'h04, 4'hC);
    strobe(8'h02, 8'h10, 4'hC);
    strobe(8'h02, 8'h40, 4'hC);
    cnt = 0;
    while (!wr_pulse && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_first_pulse", 32'(wr_pulse), 32'd1);
    #1;
    exp_q.delete();
    state = MODE_PEN;
    wait_idle("abort_clear_done");
    expect_all_zero("abort_cell_zero");

    // clr_req mid-sweep restarts the sweep from address 0.
    exp_q.push_back('{5, 5});
    strobe(8'h20, 8'h20, 4'h3);
    expect_cell("clr_pre_cell", 5, 5, 3);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("clr_restart_len", 32'(cnt), 32'd64);
    repeat (2) @(negedge clk);
    expect_cell("clr_cell_5_5", 5, 5, 0);
    expect_cell("clr_cell_0_0", 0, 0, 0);

    // Parameter corner on the 16x4x8 instance.
    @(negedge clk);
    pen_row2 = 16'h8000; pen_col2 = 4'h8; pen_data2 = 8'hA5; pen_we2 = 1'b1;
    @(negedge clk);
    pen_we2 = 1'b0;
    repeat (3) @(negedge clk);
    check("p2_pulses", 32'(pulses2), 32'd1);
    check("p2_last_row", 32'(last_row2), 32'd15);
    check("p2_last_col", 32'(last_col2), 32'd3);
    scan_row2 = 4'd15; scan_col2 = 2'd3;
    @(posedge clk);
    #1 check("p2_cell_15_3", 32'(scan_data2), 32'hA5);
    @(negedge clk);
    scan_row2 = 4'd15; scan_col2 = 2'd2;
    @(posedge clk);
    #1 check("p2_cell_15_2", 32'(scan_data2), 32'h0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_frame_ram.md
# led_frame_ram

Parametrised light-pen frame buffer, successor to the single-frame 8x8 LED RAM. It stores a ROWS x COLS array of DW-bit pixels. Pen writes arrive on one-hot row/column buses. In DRAW mode, writes are row-batched and committed after a hold timeout. Pixels are cleared by a hardware sweep on reset, on mode change, or on request. It sits between the pen/key front end and the LED scan driver, which reads through a separate binary-addressed port.

## Interface
- ROWS, 8, number of rows (2..16)
- COLS, 8, number of columns (2..16)
- DW, 4, pixel width
- HOLD_CYC, `CLOCK_FREQ`, idle cycles after the last DRAW write before commit
- RA/CA, derived, $clog2(ROWS)/$clog2(COLS)
- clk  in  1  system clock, single domain
- rst_n  in  1  reset, asynchronous, active-low
- state  in  4  top-level mode; compared against `DRAW`
- pen_we  in  1  pen write strobe (level)
- pen_row  in  ROWS  one-hot row address
- pen_col  in  COLS  one-hot column address
- pen_data  in  DW  pixel value
- clr_req  in  1  single-cycle request to clear the frame
- scan_row  in  RA  binary read row
- scan_col  in  CA  binary read column
- scan_data  out  DW  pixel at {scan_row, scan_col}, registered
- busy  out  1  clear or commit in progress; pen input is ignored while high
- last_row  out  RA  row of the most recent cell write
- last_col  out  CA  column of the most recent cell write
- wr_pulse  out  1  one-cycle pulse per committed cell write

## Operation
- pen_we edge detect: `we_d` register. The rising edge latches pen_row/pen_col/pen_data. The falling edge is the write event in non-DRAW modes.
- One-hot decode: a one-hot code with exactly one bit set is valid. Zero or multiple bits set marks the event invalid, and it is dropped silently. Invalid codes never map to 0.
- FSM states:
  - CLEAR: sweep address 0..ROWS*COLS-1, writing 0 to one cell per cycle, then go to IDLE. busy=1. wr_pulse stays 0.
  - IDLE: two cases.
    - Non-DRAW: a valid falling-edge event writes the latched data at the latched {row, col}. Set last_row/last_col to that row/col (not swapped), pulse wr_pulse.
    - DRAW: a valid rising edge loads row_buf, data_buf and col_mask (bit set), clears the timer, then goes to COLLECT.
  - COLLECT: further valid rising edges are handled by row.
    - Same row: set the mask bit, clear the timer. data_buf is kept from the first write.
    - Different row: ignored.
    - When timer == HOLD_CYC-1 with no edge that cycle, go to COMMIT.
  - COMMIT: scan col_mask from column 0 upward. Write data_buf to one flagged cell per cycle and update last_row/last_col and wr_pulse for each. After the last column, clear the mask and go to IDLE. busy=1.
- Clear triggers: clr_req, or `state` differing from its registered copy. Either trigger aborts any state the next cycle and enters CLEAR. Pending COLLECT/COMMIT data is discarded.
  - Trigger during CLEAR: the sweep restarts from address 0.
  - clr_req and a pen edge in the same cycle: clear wins.
- Read port is independent of the FSM. During CLEAR it returns the current contents, partially zeroed.

## Timing
- Reset values: scan_data=0, busy=1, last_row=0, last_col=0, wr_pulse=0. The FSM enters CLEAR from reset, so the RAM reads all-zero ROWS*COLS cycles after rst_n deasserts.
- Non-DRAW write: the cell is updated on the clock edge after the cycle the falling edge is detected. wr_pulse is high in that same cycle.
- DRAW commit: the first write occurs HOLD_CYC+1 cycles after the last accepted edge. N flagged cells take N cycles, plus one cycle to scan an empty tail.
- Read latency: 1 cycle.
- Read and write to the same cell in the same cycle returns the old value.
- Timer width is $clog2(HOLD_CYC+1). The timer saturates and does not wrap.

## Structure
- Shared headers: mode encodings (`DRAW` etc.) stay in st_state.v. `CLOCK_FREQ` stays in system_para.v. Add FSM state encodings for this block to st_state.v.
- Sub-module `onehot_dec #(N)`: one-hot code in, binary index plus valid flag out. Instantiated twice.
- RAM is a plain reg array with a single write port and a single read port, so it infers block or distributed RAM.

## Test plan
- Reset release: busy stays high 64 cycles (8x8). All 64 reads then return 0, and wr_pulse is never asserted.
- Non-DRAW mode: pen_row=8'h04, pen_col=8'h10, data=4'hA, strobe -> cell (2,4) reads 4'hA; last_row=2, last_col=4; one wr_pulse.
- DRAW mode with HOLD_CYC=16: writes (3,1), (3,5), (3,7) with data 5, then a write to (6,0) -> after 16 idle cycles, three sequential wr_pulses to (3,1), (3,5), (3,7) = 5; (6,0) stays 0.
- Invalid address: pen_col=8'h00 or 8'h18 -> no write, no wr_pulse, FSM stays in IDLE.
- Mode change mid-COMMIT: cells already written are cleared. After the sweep, all cells are 0 and the remaining commits never happen.
- Parameter sweep: ROWS=16, COLS=4, DW=8 -> a corner write at (15,3) reads back correctly, and the clear sweep takes 64 cycles.
